// File: rtl/ram_bus_master.sv
// ram_bus_master: initiator side of the 16x4 asynchronous RAM bus.
// Turns single-cycle CPU requests into setup / strobe / hold bus cycles and
// returns a one-cycle response pulse carrying the read data.
// Optional feature macro: RAM_READBACK_VERIFY_EN. When defined, every write is
// followed by a read of the same address, and rsp_err flags a readback mismatch.
module ram_bus_master #(
  parameter int STROBE_CYCLES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_write,
  input  logic [3:0] req_addr,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_rdata,
  output logic       rsp_err,
  output logic       busy,
  output logic [3:0] mem_addr,
  output logic [3:0] mem_datain,
  output logic       mem_csn,
  output logic       mem_rwn,
  input  logic [3:0] mem_dataout
);

  // Strobe counter counts down to zero; zero marks the last strobe cycle.
  localparam logic [3:0] CNT_INIT = 4'(STROBE_CYCLES - 1);

`ifdef RAM_READBACK_VERIFY_EN
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RESP, VSETUP, VSTROBE, VHOLD
  } state_t;
  logic err_q;
`else
  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RESP
  } state_t;
`endif

  state_t     state;
  logic [3:0] cnt;
  logic       wr;

  // Bus sequencer: every output is a register updated on the state transition,
  // so addr/datain/rwn only move while csn is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      wr         <= 1'b0;
      req_ready  <= 1'b1;
      busy       <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 4'd0;
      mem_addr   <= 4'd0;
      mem_datain <= 4'd0;
      mem_csn    <= 1'b1;
      mem_rwn    <= 1'b1;
`ifdef RAM_READBACK_VERIFY_EN
      err_q      <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mem_addr   <= req_addr;
            mem_datain <= req_wdata;
            wr         <= req_write;
            mem_rwn    <= ~req_write;
            req_ready  <= 1'b0;
            busy       <= 1'b1;
`ifdef RAM_READBACK_VERIFY_EN
            err_q      <= 1'b0;
`endif
            state      <= SETUP;
          end
        end
        SETUP: begin
          mem_csn <= 1'b0;
          cnt     <= CNT_INIT;
          state   <= STROBE;
        end
        STROBE: begin
          if (cnt == 4'd0) begin
            // Sample on the last strobe edge, while csn is still low.
            mem_csn <= 1'b1;
            if (!wr) rsp_rdata <= mem_dataout;
            state <= HOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        HOLD: begin
          mem_rwn <= 1'b1;
`ifdef RAM_READBACK_VERIFY_EN
          if (wr) begin
            state <= VSETUP;
          end else begin
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
`else
          rsp_valid <= 1'b1;
          state     <= RESP;
`endif
        end
`ifdef RAM_READBACK_VERIFY_EN
        VSETUP: begin
          mem_csn <= 1'b0;
          cnt     <= CNT_INIT;
          state   <= VSTROBE;
        end
        VSTROBE: begin
          if (cnt == 4'd0) begin
            mem_csn   <= 1'b1;
            rsp_rdata <= mem_dataout;
            err_q     <= (mem_dataout != mem_datain);
            state     <= VHOLD;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        VHOLD: begin
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
`endif
        RESP: begin
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          mem_csn   <= 1'b1;
          mem_rwn   <= 1'b1;
          req_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef RAM_READBACK_VERIFY_EN
  assign rsp_err = err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_ram_bus_master.sv
// Testbench for ram_bus_master: level-sensitive RAM model on the bus, a
// scoreboard of expected responses, and a bus-invariant monitor.
module tb_ram_bus_master;

  localparam int S = 2;
  localparam int LAT_RD = S + 3;
`ifdef RAM_READBACK_VERIFY_EN
  localparam int LAT_WR = 2 * S + 5;
`else
  localparam int LAT_WR = S + 3;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_write = 1'b0;
  logic [3:0] req_addr = 4'd0;
  logic [3:0] req_wdata = 4'd0;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;
  logic       rsp_err;
  logic       busy;
  logic [3:0] mem_addr;
  logic [3:0] mem_datain;
  logic       mem_csn;
  logic       mem_rwn;
  logic [3:0] mem_dataout;

  ram_bus_master #(.STROBE_CYCLES(S)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .busy(busy), .mem_addr(mem_addr), .mem_datain(mem_datain),
    .mem_csn(mem_csn), .mem_rwn(mem_rwn), .mem_dataout(mem_dataout)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // RAM model: writes are level-sensitive; the bus floats (junk) unless reading.
  logic [3:0] ram [16];
  logic [3:0] junk = 4'hE;
  logic       force_zero = 1'b0;

  always @(mem_csn, mem_rwn, mem_addr, mem_datain)
    if (!mem_csn && !mem_rwn) ram[mem_addr] = mem_datain;

  assign mem_dataout = (!mem_csn && mem_rwn) ? (force_zero ? 4'h0 : ram[mem_addr]) : junk;

  int cyc = 0;
  always @(posedge clk) begin
    cyc++;
    junk = 4'($urandom);
  end

  // Scoreboard and reference memory.
  typedef struct {
    logic [3:0] rdata;
    logic       err;
    int         acc;
    int         lat;
  } exp_t;
  exp_t       sbq[$];
  logic [3:0] ref_mem [16];
  logic [3:0] exp_last = 4'd0;
  int         rsp_cnt = 0;
  int         low_cnt = 0;
  bit         prev_low = 0;
  logic [8:0] prev_bus = 9'd0;

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      low_cnt  = 0;
      prev_low = 0;
    end else begin
      if (req_valid && req_ready) begin
        if (req_write) begin
          ref_mem[req_addr] = req_wdata;
`ifdef RAM_READBACK_VERIFY_EN
          exp_last = force_zero ? 4'h0 : req_wdata;
          e.err = force_zero;
`else
          e.err = 1'b0;
`endif
          e.lat = LAT_WR;
        end else begin
          exp_last = ref_mem[req_addr];
          e.err = 1'b0;
          e.lat = LAT_RD;
        end
        e.rdata = exp_last;
        e.acc   = cyc;
        sbq.push_back(e);
      end
      if (rsp_valid) begin
        rsp_cnt++;
        if (sbq.size() == 0) begin
          check("rsp_spurious", 32'(rsp_valid), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("rsp_rdata", 32'(rsp_rdata), 32'(e.rdata));
          check("rsp_err", 32'(rsp_err), 32'(e.err));
          check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
      if (!mem_csn) begin
        if (prev_low) check("bus_stable", 32'({mem_addr, mem_datain, mem_rwn}), 32'(prev_bus));
        prev_bus = {mem_addr, mem_datain, mem_rwn};
        prev_low = 1;
        low_cnt++;
      end else begin
        if (low_cnt != 0) check("csn_len", 32'(low_cnt), 32'(S));
        low_cnt  = 0;
        prev_low = 0;
      end
    end
  end

  task automatic send(input logic w, input logic [3:0] a, input logic [3:0] d, input bit keep);
    int n;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    req_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("timeout_send", 32'(req_ready), 32'd1);
    @(posedge clk);
    #1;
    if (!keep) req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sbq.size() != 0 || !req_ready) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) check("timeout_idle", 32'(sbq.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int r0;
    int n;
    for (int i = 0; i < 16; i++) begin
      ram[i]     = 4'd0;
      ref_mem[i] = 4'd0;
    end

    // Reset and idle state
    repeat (2) @(posedge clk);
    #1;
    check("rst_csn", 32'(mem_csn), 32'd1);
    check("rst_rwn", 32'(mem_rwn), 32'd1);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rspv", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_bus", 32'({mem_addr, mem_datain, rsp_rdata, rsp_err}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_csn", 32'(mem_csn), 32'd1);
    check("idle_ready", 32'(req_ready), 32'd1);

    // Write then read
    send(1'b1, 4'h3, 4'hA, 1'b0);
    check("busy_after_accept", 32'(busy), 32'd1);
    wait_idle();
    send(1'b0, 4'h3, 4'h0, 1'b0);
    wait_idle();
    check("wr_rd_data", 32'(rsp_rdata), 32'hA);

    // Back-to-back with req_valid held high
    r0 = rsp_cnt;
    send(1'b1, 4'hF, 4'h5, 1'b1);
    send(1'b0, 4'hF, 4'h0, 1'b1);
    send(1'b1, 4'h0, 4'hA, 1'b1);
    send(1'b0, 4'h0, 4'h0, 1'b0);
    wait_idle();
    check("b2b_count", 32'(rsp_cnt - r0), 32'd4);
    send(1'b0, 4'hF, 4'h0, 1'b0);
    wait_idle();
    check("wrap_addr_f", 32'(rsp_rdata), 32'h5);

`ifdef RAM_READBACK_VERIFY_EN
    // Readback mismatch, then a clean verified write
    force_zero = 1'b1;
    send(1'b1, 4'h2, 4'h9, 1'b0);
    wait_idle();
    force_zero = 1'b0;
    check("verify_err_hold", 32'(rsp_err), 32'd1);
    send(1'b1, 4'h2, 4'h9, 1'b0);
    wait_idle();
    check("verify_ok", 32'(rsp_err), 32'd0);
`endif

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      send(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom),
           (i != 199) && ($urandom_range(0, 1) == 1));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
      #1;
    end
    wait_idle();

    // Reset in the middle of a write strobe
    r0 = rsp_cnt;
    send(1'b1, 4'h6, 4'h7, 1'b0);
    n = 0;
    while (mem_csn && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_strobe", 32'(mem_csn), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("abort_csn", 32'(mem_csn), 32'd1);
    check("abort_ready", 32'(req_ready), 32'd1);
    sbq.delete();
    exp_last = 4'd0;
    ref_mem[6] = 4'h7; // the strobe already drove the level-sensitive write
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_norsp", 32'(rsp_cnt - r0), 32'd0);

    // Normal operation after the abort
    send(1'b1, 4'h9, 4'hC, 1'b0);
    wait_idle();
    send(1'b0, 4'h9, 4'h0, 1'b0);
    wait_idle();
    check("post_abort_rd", 32'(rsp_rdata), 32'hC);
    send(1'b0, 4'h6, 4'h0, 1'b0);
    wait_idle();
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
